// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges load results and buffered ALU results
// into one registered register-file / PC write port.
module writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        rwboolean,
    output logic [3:0]  rwselector,
    output logic [31:0] rwdata,
    output logic        pc_write,
    output logic [31:0] pc_data,
    output logic [14:0] pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          accept;
    logic          has_head;
    logic          issue;
    logic [3:0]    issue_rd;
    logic [31:0]   issue_data;
    logic          enq;
    logic          deq;

    assign alu_ready = (count < CW'(DEPTH));
    assign accept    = alu_valid && alu_ready;
    assign has_head  = (count != '0);

    // Loads always win; the bypass path only opens with an empty buffer
    // so ALU results can never overtake older buffered ones.
    always_comb begin
        issue      = 1'b0;
        issue_rd   = '0;
        issue_data = '0;
        deq        = 1'b0;
        if (mem_valid) begin
            issue      = 1'b1;
            issue_rd   = mem_rd;
            issue_data = mem_data;
        end else if (has_head) begin
            issue      = 1'b1;
            issue_rd   = fifo_rd[rptr];
            issue_data = fifo_data[rptr];
            deq        = 1'b1;
        end else if (accept) begin
            issue      = 1'b1;
            issue_rd   = alu_rd;
            issue_data = alu_data;
        end
        enq = accept && (mem_valid || has_head);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (fifo_rd[rptr + PW'(i)] != 4'd15) begin
                    pending[fifo_rd[rptr + PW'(i)]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wptr]   <= alu_rd;
            fifo_data[wptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + PW'(1);
            if (deq) rptr <= rptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwboolean  <= 1'b0;
            rwselector <= '0;
            rwdata     <= '0;
            pc_write   <= 1'b0;
            pc_data    <= '0;
        end else begin
            rwboolean <= 1'b0;
            pc_write  <= 1'b0;
            if (issue) begin
                if (issue_rd == 4'd15) begin
                    pc_write <= 1'b1;
                    pc_data  <= issue_data;
                end else begin
                    rwboolean  <= 1'b1;
                    rwselector <= issue_rd;
                    rwdata     <= issue_data;
                end
            end
        end
    end

endmodule
